// File: rtl/riscv_mem.sv
// Program/data memory responder with a streaming boot loader for the single-cycle core.
// Reads are combinational; the loader stalls only in RUN (ld_ready_o low) and holds the core in reset until the image completes.
module riscv_mem #(
    parameter int unsigned XLen      = 32,
    parameter int unsigned ILen      = 32,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned PmemWords = 1024,
    parameter int unsigned DmemWords = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] pmem_addr_i,
    output logic [ILen-1:0]      pmem_rdata_o,
    input  logic [AddrWidth-1:0] dmem_addr_i,
    output logic [XLen-1:0]      dmem_rdata_o,
    input  logic                 dmem_we_i,
    input  logic [XLen-1:0]      dmem_wdata_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [ILen-1:0]      ld_data_i,
    input  logic                 ld_restart_i,
    output logic                 core_rst_no,
    output logic                 load_done_o,
    output logic                 ld_ovf_o
);

    localparam int unsigned PIdxW = $clog2(PmemWords);
    localparam int unsigned DIdxW = $clog2(DmemWords);
    localparam int unsigned CW    = (AddrWidth > 31) ? AddrWidth + 1 : 33;

    typedef enum logic [1:0] {HDR, LOAD, RUN} state_e;

    state_e               state_q, state_d;
    logic [31:0]          n_q, n_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 core_rst_q, core_rst_d;

    logic [ILen-1:0] pmem [PmemWords];
    logic [XLen-1:0] dmem [DmemWords];

    logic             ld_fire;
    logic             pmem_we;
    logic             cnt_in_range;
    logic             last_beat;
    logic [CW-1:0]    cnt_inc;
    logic [PIdxW-1:0] pmem_idx;
    logic [DIdxW-1:0] dmem_idx;
    logic             unused_addr_bits;

    assign pmem_idx         = pmem_addr_i[2 +: PIdxW];
    assign dmem_idx         = dmem_addr_i[2 +: DIdxW];
    assign unused_addr_bits = ^{pmem_addr_i, dmem_addr_i};

    assign pmem_rdata_o = pmem[pmem_idx];
    assign dmem_rdata_o = dmem[dmem_idx];

    assign ld_ready_o   = (state_q != RUN);
    assign load_done_o  = (state_q == RUN);
    assign core_rst_no  = core_rst_q;
    assign ld_ovf_o     = ovf_q;

    assign ld_fire      = ld_valid_i & ld_ready_o;
    // Wide compare so an oversized N never matches a wrapped counter.
    assign cnt_inc      = CW'(cnt_q) + CW'(1);
    assign last_beat    = (cnt_inc == CW'(n_q));
    assign cnt_in_range = (CW'(cnt_q) < CW'(PmemWords));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        pmem_we = 1'b0;
        unique case (state_q)
            HDR: begin
                if (ld_fire) begin
                    n_d     = 32'(ld_data_i);
                    cnt_d   = '0;
                    state_d = (ld_data_i == '0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    if (cnt_in_range) begin
                        pmem_we = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + AddrWidth'(1);
                    if (last_beat) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ld_restart_i) begin
                    state_d = HDR;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = HDR;
        endcase
        core_rst_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HDR;
            n_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            core_rst_q <= core_rst_d;
        end
    end

    // Arrays are deliberately unreset so images and data survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (pmem_we) begin
            pmem[cnt_q[PIdxW-1:0]] <= ld_data_i;
        end
        if (dmem_we_i && core_rst_q) begin
            dmem[dmem_idx] <= dmem_wdata_i;
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for riscv_mem (PmemWords=4) against a transaction-level loader/memory model.
module tb_riscv_mem;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] pmem_addr_i = '0;
    logic [31:0] pmem_rdata_o;
    logic [15:0] dmem_addr_i = '0;
    logic [31:0] dmem_rdata_o;
    logic        dmem_we_i = 1'b0;
    logic [31:0] dmem_wdata_i = '0;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [31:0] ld_data_i = '0;
    logic        ld_restart_i = 1'b0;
    logic        core_rst_no;
    logic        load_done_o;
    logic        ld_ovf_o;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    riscv_mem #(
        .XLen(32), .ILen(32), .AddrWidth(16), .PmemWords(4), .DmemWords(1024)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pmem_addr_i(pmem_addr_i), .pmem_rdata_o(pmem_rdata_o),
        .dmem_addr_i(dmem_addr_i), .dmem_rdata_o(dmem_rdata_o),
        .dmem_we_i(dmem_we_i), .dmem_wdata_i(dmem_wdata_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
        .ld_restart_i(ld_restart_i), .core_rst_no(core_rst_no),
        .load_done_o(load_done_o), .ld_ovf_o(ld_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: image is "complete" once header plus N words have been taken.
    logic [31:0] m_pmem [4];
    bit          m_pk   [4];
    logic [31:0] m_dmem [1024];
    bit          m_dk   [1024];
    bit          m_run = 1'b0;
    bit          m_hdr_seen = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_rem = 0;
    int          m_idx = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_run = 1'b0;
            m_hdr_seen = 1'b0;
            m_ovf = 1'b0;
            m_idx = 0;
        end else if (m_run) begin
            if (dmem_we_i) begin
                m_dmem[dmem_addr_i[11:2]] = dmem_wdata_i;
                m_dk[dmem_addr_i[11:2]] = 1'b1;
            end
            if (ld_restart_i) begin
                m_run = 1'b0;
                m_ovf = 1'b0;
            end
        end else if (ld_valid_i) begin
            if (!m_hdr_seen) begin
                if (ld_data_i == 32'd0) begin
                    m_run = 1'b1;
                end else begin
                    m_hdr_seen = 1'b1;
                    m_rem = int'(ld_data_i);
                    m_idx = 0;
                end
            end else begin
                if (m_idx < 4) begin
                    m_pmem[m_idx] = ld_data_i;
                    m_pk[m_idx] = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
                m_idx++;
                m_rem--;
                if (m_rem == 0) begin
                    m_run = 1'b1;
                    m_hdr_seen = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("ld_ready_o", 32'(ld_ready_o), 32'(!m_run));
            check("load_done_o", 32'(load_done_o), 32'(m_run));
            check("core_rst_no", 32'(core_rst_no), 32'(m_run));
            check("ld_ovf_o", 32'(ld_ovf_o), 32'(m_ovf));
            if (m_pk[pmem_addr_i[3:2]])
                check("pmem_rdata", pmem_rdata_o, m_pmem[pmem_addr_i[3:2]]);
            if (m_dk[dmem_addr_i[11:2]])
                check("dmem_rdata", dmem_rdata_o, m_dmem[dmem_addr_i[11:2]]);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        ld_valid_i = 1'b1;
        ld_data_i = d;
        tick();
        ld_valid_i = 1'b0;
    endtask

    task automatic pulse_restart();
        ld_restart_i = 1'b1;
        tick();
        ld_restart_i = 1'b0;
    endtask

    task automatic rd_pmem(input logic [15:0] a, input logic [31:0] exp, input string name);
        pmem_addr_i = a;
        #1;
        check(name, pmem_rdata_o, exp);
    endtask

    initial begin
        // Reset, with a beat presented that must not be taken
        ld_valid_i = 1'b1;
        ld_data_i = 32'd5;
        tick();
        tick();
        cmp_en = 1'b1;
        check("rst_core_rst_no", 32'(core_rst_no), 32'd0);
        check("rst_ld_ready", 32'(ld_ready_o), 32'd1);
        check("rst_load_done", 32'(load_done_o), 32'd0);
        check("rst_ld_ovf", 32'(ld_ovf_o), 32'd0);
        tick();
        ld_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic load, valid held high
        beat(32'd3);
        beat(32'h0000_0013);
        beat(32'h0010_0093);
        check("basic_not_done", 32'(load_done_o), 32'd0);
        beat(32'h0020_8113);
        check("basic_ready_low", 32'(ld_ready_o), 32'd0);
        check("basic_done", 32'(load_done_o), 32'd1);
        check("basic_core_rst", 32'(core_rst_no), 32'd1);
        rd_pmem(16'h0000, 32'h0000_0013, "basic_w0");
        rd_pmem(16'h0004, 32'h0010_0093, "basic_w1");
        rd_pmem(16'h0008, 32'h0020_8113, "basic_w2");

        // Data port stores
        dmem_addr_i = 16'h0104;
        dmem_wdata_i = 32'h1111_1111;
        dmem_we_i = 1'b1;
        tick();
        dmem_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("dmem_same_cycle_old", dmem_rdata_o, 32'h1111_1111);
        tick();
        dmem_we_i = 1'b0;
        #1;
        check("dmem_new", dmem_rdata_o, 32'hDEAD_BEEF);
        dmem_addr_i = 16'h0107;
        #1;
        check("dmem_alias_0107", dmem_rdata_o, 32'hDEAD_BEEF);

        // Restart with a store in the same cycle
        dmem_addr_i = 16'h0104;
        dmem_wdata_i = 32'h2222_2222;
        dmem_we_i = 1'b1;
        ld_restart_i = 1'b1;
        tick();
        dmem_we_i = 1'b0;
        ld_restart_i = 1'b0;
        check("restart_core_rst", 32'(core_rst_no), 32'd0);
        check("restart_ready", 32'(ld_ready_o), 32'd1);
        check("restart_store_kept", dmem_rdata_o, 32'h2222_2222);
        dmem_wdata_i = 32'h3333_3333;
        dmem_we_i = 1'b1;
        tick();
        dmem_we_i = 1'b0;
        #1;
        check("store_in_reset_ignored", dmem_rdata_o, 32'h2222_2222);
        beat(32'd1);
        beat(32'hAAAA_0001);
        check("reload_done", 32'(load_done_o), 32'd1);
        rd_pmem(16'h0000, 32'hAAAA_0001, "reload_w0");
        rd_pmem(16'h0004, 32'h0010_0093, "reload_w1_kept");

        // Gaps in the stream
        pulse_restart();
        ld_valid_i = 1'b1; ld_data_i = 32'd2; tick();
        ld_valid_i = 1'b0; tick();
        ld_valid_i = 1'b1; ld_data_i = 32'hB000_0000; tick();
        ld_valid_i = 1'b0; tick();
        check("gap_not_done", 32'(load_done_o), 32'd0);
        ld_valid_i = 1'b1; ld_data_i = 32'hB000_0001; tick();
        ld_valid_i = 1'b0;
        check("gap_done", 32'(load_done_o), 32'd1);
        rd_pmem(16'h0000, 32'hB000_0000, "gap_w0");
        rd_pmem(16'h0004, 32'hB000_0001, "gap_w1");

        // Beats offered in RUN are refused
        ld_valid_i = 1'b1; ld_data_i = 32'h1234_5678; tick(); tick();
        ld_valid_i = 1'b0;
        check("run_refuse_ready", 32'(ld_ready_o), 32'd0);
        rd_pmem(16'h0000, 32'hB000_0000, "run_refuse_w0");

        // Zero-length image
        pulse_restart();
        beat(32'd0);
        check("zero_len_done", 32'(load_done_o), 32'd1);

        // Oversized image
        pulse_restart();
        beat(32'd6);
        for (int i = 1; i <= 6; i++) begin
            beat(32'hC0DE_0000 + 32'(i));
            if (i == 4) check("ovf_not_yet", 32'(ld_ovf_o), 32'd0);
            if (i == 5) check("ovf_set_mid", 32'(ld_ovf_o), 32'd1);
        end
        check("ovf_flag", 32'(ld_ovf_o), 32'd1);
        check("ovf_done", 32'(load_done_o), 32'd1);
        rd_pmem(16'h0000, 32'hC0DE_0001, "ovf_w0");
        rd_pmem(16'h0004, 32'hC0DE_0002, "ovf_w1");
        rd_pmem(16'h0008, 32'hC0DE_0003, "ovf_w2");
        rd_pmem(16'h000C, 32'hC0DE_0004, "ovf_w3");
        rd_pmem(16'h0010, 32'hC0DE_0001, "pmem_alias_16");

        pulse_restart();
        check("restart_clears_ovf", 32'(ld_ovf_o), 32'd0);

        // rst_ni mid-load
        beat(32'd5);
        beat(32'hE000_0001);
        beat(32'hE000_0002);
        rst_ni = 1'b0;
        #1;
        check("midrst_core_rst", 32'(core_rst_no), 32'd0);
        check("midrst_ready", 32'(ld_ready_o), 32'd1);
        check("midrst_done", 32'(load_done_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        beat(32'd0);
        check("midrst_new_header", 32'(load_done_o), 32'd1);
        rd_pmem(16'h0000, 32'hE000_0001, "midrst_w0_kept");
        rd_pmem(16'h0004, 32'hE000_0002, "midrst_w1_kept");
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mem.md
# riscv_mem

Memory responder for the single-cycle RISC-V core. It serves the core's program-memory fetch port and data-memory load/store port. A boot loader accepts a program image over a valid/ready stream and writes it into program memory, holding the core in reset until the image is complete. It sits beside the core in the top level and drives the core's `rst_ni`.

## Interface
- `XLen`, default 32: data word width.
- `ILen`, default 32: instruction width; equals `XLen`.
- `AddrWidth`, default 16: byte-address width of both core ports.
- `PmemWords`, default 1024: program memory depth in words; power of two, at most 2^(`AddrWidth`-2).
- `DmemWords`, default 1024: data memory depth in words; same constraints as `PmemWords`.

- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `pmem_addr_i`, in, `AddrWidth`: core fetch byte address.
- `pmem_rdata_o`, out, `ILen`: instruction at `pmem_addr_i`.
- `dmem_addr_i`, in, `AddrWidth`: core load/store byte address.
- `dmem_rdata_o`, out, `XLen`: data word at `dmem_addr_i`.
- `dmem_we_i`, in, 1: store enable.
- `dmem_wdata_i`, in, `XLen`: store data.
- `ld_valid_i`, in, 1: loader beat valid.
- `ld_ready_o`, out, 1: loader beat accepted when high together with `ld_valid_i`.
- `ld_data_i`, in, `ILen`: loader beat payload.
- `ld_restart_i`, in, 1: one-cycle pulse; requests a reload.
- `core_rst_no`, out, 1: reset to the core, active-low, registered.
- `load_done_o`, out, 1: high while state is RUN.
- `ld_ovf_o`, out, 1: sticky flag; image exceeded `PmemWords`.

## Operation
- Word index:
  - pmem index = `pmem_addr_i[2 +: log2(PmemWords)]`; dmem index = `dmem_addr_i[2 +: log2(DmemWords)]`.
  - Bits [1:0] and the upper bits are ignored, so the memory aliases across the address space.
- Reads on both ports are combinational (zero latency), as the single-cycle core requires.
- Memory arrays are not reset. Contents persist across `rst_ni` and across reloads.
- Stores:
  - Data memory is written at the rising edge when `dmem_we_i`=1 and `core_rst_no`=1.
  - Stores are ignored while the core is held in reset.
  - Full-word stores only; no byte enables.
- Loader FSM, states HDR, LOAD, RUN:
  - HDR: the first accepted beat is the word count N, stored in a 32-bit register; word counter cleared.
    - N=0: go to RUN.
    - Otherwise: go to LOAD.
  - LOAD: each accepted beat writes `ld_data_i` to pmem[counter], then the counter increments.
    - After the Nth beat: go to RUN.
    - A beat with counter ≥ `PmemWords` is accepted and discarded, and sets `ld_ovf_o`.
  - RUN: `ld_ready_o`=0 and `core_rst_no`=1.
    - `ld_restart_i`=1: go to HDR; `core_rst_no` drops on the same edge; `ld_ovf_o` cleared.
- `ld_ready_o` = (state ≠ RUN), combinational from the state register.
- `ld_restart_i` is ignored in HDR and LOAD.
- `load_done_o` = (state == RUN).

## Timing
- Reset values: state HDR, `core_rst_no`=0, `ld_ready_o`=1, `load_done_o`=0, `ld_ovf_o`=0, counter 0.
- Beats presented while `rst_ni`=0 are not accepted.
- Handshake: a transfer occurs at the rising edge where `ld_valid_i` & `ld_ready_o`. The pmem write is committed at that same edge.
- Last beat accepted at edge k:
  - state=RUN, `load_done_o`=1, `core_rst_no`=1 after edge k.
  - The core's first fetch (address 0) occurs in cycle k+1.
- Restart:
  - `ld_restart_i` sampled high at edge k: `core_rst_no`=0 and `ld_ready_o`=1 after edge k.
  - A `dmem_we_i` in the cycle before edge k is committed.
- `rst_ni` asserted mid-LOAD: immediate return to HDR with `core_rst_no`=0. Words already written remain. The next accepted beat is treated as a new header.
- Simultaneous pmem read of the word being loaded: `pmem_rdata_o` shows the old value until the write edge, and the new value after it.
- Counter is `AddrWidth` bits wide and saturates at its maximum; it does not wrap while counting an oversized N.

## Test plan
- Basic load: header 3, beats 0x00000013, 0x00100093, 0x00208113 with `ld_valid_i` held high.
  - `ld_ready_o` falls and `core_rst_no` rises the cycle after the 4th beat.
  - pmem_addr 0/4/8 read back the three words.
- Backpressure and gaps: header 2 with `ld_valid_i` toggling every other cycle.
  - Only valid&ready edges advance the counter.
  - Both words land at indices 0 and 1; RUN is reached after the 2nd data beat.
- Data port: in RUN, store 0xDEADBEEF at address 0x0104.
  - Same-cycle read shows the old value; next cycle reads 0xDEADBEEF.
  - Address 0x0107 returns the same word.
  - The same store with `core_rst_no`=0 leaves memory unchanged.
- Zero-length and overflow:
  - Header 0: RUN is reached one cycle after the header beat.
  - With `PmemWords`=4, header 6: all 6 beats are accepted, `ld_ovf_o`=1, pmem indices 0..3 hold beats 1..4.
- Restart and reset mid-load:
  - `ld_restart_i` pulse in RUN drops `core_rst_no` next edge and clears `ld_ovf_o`; a new image of 1 word overwrites index 0 only.
  - `rst_ni` pulsed after 2 of 5 data beats returns to HDR; those 2 words are preserved.
- Reset values: while `rst_ni`=0, check `core_rst_no`=0, `ld_ready_o`=1, `load_done_o`=0, `ld_ovf_o`=0, and that a beat presented during reset is not consumed.
